// File: rtl/axis_pkg.sv
// Shared widths and state encoding for the byte-stream to word reassembly path.
package axis_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } asm_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axis_word_fifo.sv
// Small synchronous word FIFO; the head word is presented combinationally so a
// push is visible at the output one cycle later.
module axis_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is not reset, so the head is forced to zero while empty.
    assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axis_word_assembler.sv
// Reassembles MSB-first byte packets into words; malformed packets are dropped
// and counted, good words queue in a FIFO towards the sink.
module axis_word_assembler
    import axis_pkg::*;
#(
    parameter int BYTES = BYTES_PER_WORD,
    parameter int DEPTH = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [BYTE_W-1:0]       TDATA_in,
    input  logic                    TLAST_in,
    input  logic                    TVALID_in,
    output logic                    TREADY_out,
    output logic [BYTE_W*BYTES-1:0] WORD_out,
    output logic                    WORD_VALID_out,
    input  logic                    WORD_READY_in,
    output logic                    ERR_out,
    output logic [15:0]             PKT_COUNT,
    output logic [7:0]              ERR_COUNT
);

    localparam int W     = BYTE_W * BYTES;
    localparam int CNT_W = $clog2(BYTES);

    asm_state_t       state_reg;
    logic             en_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [W-1:0]     shreg_reg;
    logic             err_reg;
    logic [15:0]      pkt_count_reg;
    logic [7:0]       err_count_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             last_slot;
    logic             push;
    logic [W-1:0]     assembled;

    // DRAIN swallows the tail of an over-long packet regardless of FIFO space.
    assign TREADY_out = en_reg && ((state_reg == DRAIN) || !fifo_full);
    assign accept     = TVALID_in && TREADY_out;
    assign last_slot  = (cnt_reg == CNT_W'(BYTES - 1));
    assign assembled  = {shreg_reg[W-BYTE_W-1:0], TDATA_in};
    assign push       = accept && (state_reg == ACCUM) && TLAST_in && last_slot;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            en_reg        <= 1'b0;
            state_reg     <= ACCUM;
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            err_reg       <= 1'b0;
            pkt_count_reg <= '0;
            err_count_reg <= '0;
        end else begin
            en_reg  <= 1'b1;
            err_reg <= 1'b0;
            if (accept) begin
                case (state_reg)
                    ACCUM: begin
                        shreg_reg <= assembled;
                        if (TLAST_in) begin
                            cnt_reg <= '0;
                            if (last_slot) begin
                                pkt_count_reg <= pkt_count_reg + 16'd1;
                            end else begin
                                err_reg       <= 1'b1;
                                err_count_reg <= sat_inc8(err_count_reg);
                            end
                        end else if (last_slot) begin
                            cnt_reg       <= '0;
                            err_reg       <= 1'b1;
                            err_count_reg <= sat_inc8(err_count_reg);
                            state_reg     <= DRAIN;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (TLAST_in) state_reg <= ACCUM;
                    end
                    default: state_reg <= ACCUM;
                endcase
            end
        end
    end

    assign ERR_out   = err_reg;
    assign PKT_COUNT = pkt_count_reg;
    assign ERR_COUNT = err_count_reg;

    axis_word_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .push      (push),
        .push_data (assembled),
        .pop       (WORD_READY_in),
        .head      (WORD_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign WORD_VALID_out = !fifo_empty;

endmodule

// File: doc/axis_word_assembler.md
# axis_word_assembler

Downstream stage of the byte-serial adder path: consumes the 8-bit AXI-Stream result packets (4 bytes, MSB first, TLAST on the final byte) and reassembles each into one 32-bit word. Malformed packets are detected, discarded and counted. Good words are buffered in a small FIFO and offered on a 32-bit valid/ready port to the sink (scoreboard/register bank).

## Interface
- `BYTES`, default 4: bytes per packet; word width = 8*BYTES.
- `DEPTH`, default 4: output FIFO depth in words; must be a power of 2, ≥2.
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESETn`  in  1  reset, asynchronous, active-low.
- `TDATA_in`  in  8  stream byte.
- `TLAST_in`  in  1  last byte of packet.
- `TVALID_in`  in  1  byte valid.
- `TREADY_out`  out  1  byte accepted when TVALID_in && TREADY_out.
- `WORD_out`  out  32  FIFO head word.
- `WORD_VALID_out`  out  1  FIFO not empty.
- `WORD_READY_in`  in  1  sink pops the head when WORD_VALID_out && WORD_READY_in.
- `ERR_out`  out  1  one-cycle pulse per discarded packet.
- `PKT_COUNT`  out  16  good words pushed, wraps at 2^16.
- `ERR_COUNT`  out  8  discarded packets, saturates at 255.

## Operation
- Reset values: TREADY_out 0, WORD_VALID_out 0, WORD_out 0, ERR_out 0, both counters 0, state ACCUM, byte count 0, shift register 0, FIFO empty.
- `en` flop: 0 in reset, 1 from first clock edge after deassertion; TREADY_out is forced 0 while en=0.
- States:
  - ACCUM: TREADY_out = en && !fifo_full. On accept: shreg <= {shreg[23:0], TDATA_in}, cnt <= cnt+1.
    - TLAST_in && cnt==BYTES-1: push {shreg[23:0], TDATA_in}, PKT_COUNT+1, cnt <= 0.
    - TLAST_in && cnt<BYTES-1 (short): discard, ERR_out pulse, ERR_COUNT+1 (sat), cnt <= 0, stay ACCUM.
    - !TLAST_in && cnt==BYTES-1 (long): discard, ERR_out pulse, ERR_COUNT+1, cnt <= 0, go DRAIN.
  - DRAIN: TREADY_out = en (independent of FIFO); bytes discarded; accepted TLAST_in returns to ACCUM. No further ERR_out for the same packet.
- Single-byte packet with TLAST (BYTES=4) is short → error.
- FIFO: push and pop in the same cycle when non-empty: occupancy unchanged, both take effect. Pop on empty ignored (WORD_VALID_out low, so sink cannot pop). Push never occurs when full (TREADY_out gated in ACCUM).
- Pointers log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ, lower bits equal.
- WORD_out must hold stable while WORD_VALID_out && !WORD_READY_in.
- Asynchronous reset mid-packet: partial shreg/cnt dropped, FIFO emptied, counters cleared; no ERR_out.

## Timing
- Last byte accepted at edge N → word at FIFO head and WORD_VALID_out high after edge N (visible cycle N+1) when FIFO was empty.
- ERR_out high the cycle after the offending accept edge, for exactly one cycle.
- TREADY_out combinational from registered state/FIFO flags only (no path from TVALID_in or WORD_READY_in).
- Throughput: one byte per cycle sustained while FIFO not full; FIFO full → TREADY_out low the cycle after the filling push; one pop frees it the following cycle.

## Structure
- Shared package `axis_pkg`: BYTE_W=8, WORD_W=32, default BYTES_PER_WORD=4, state enum {ACCUM, DRAIN}.
- Sub-module `axis_word_fifo` (parameterised WIDTH, DEPTH sync FIFO with full/empty); assembler FSM, counters and error logic stay in the top module.

## Test plan
- Bytes 0x12,0x34,0x56,0x78(TLAST), WORD_READY_in=1 → WORD_out=0x12345678 valid one cycle after last accept, PKT_COUNT=1, ERR_out never high.
- Short packet 0xAA,0xBB(TLAST) then good 0x01,0x02,0x03,0x04(TLAST) → one ERR_out pulse, ERR_COUNT=1, only word 0x01020304 emitted.
- Long packet 0x11..0x66 (6 bytes, TLAST on 6th) → ERR_out once on 4th byte, bytes 5–6 drained with TREADY_out=1, no word, next good packet assembles correctly.
- WORD_READY_in=0, send 5 good packets (DEPTH=4) → TREADY_out low after 4th push; release ready → words popped in order, 5th packet then accepted, PKT_COUNT=5.
- Simultaneous push/pop with 2 words queued → occupancy stays 2, order preserved; 256 short packets → ERR_COUNT saturates at 255.
- Assert ARESETn mid-packet after 2 bytes → all outputs at reset values asynchronously, TREADY_out returns high one edge after deassertion, next 4-byte packet yields correct word.
